// File: rtl/lcd_pkg.sv
// Shared types and command constants for the character-LCD frame sequencer.
package lcd_pkg;

  localparam int unsigned ADDR_W = 5;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam logic [3:0] INIT_NIB    = 4'h3;
  localparam logic [3:0] FOURBIT_NIB = 4'h2;

  typedef enum logic [3:0] {
    StPwrup, StInitA, StInitB, StInitC, StInit4b, StCfg,
    StIdle, StAddr1, StLine1, StAddr2, StLine2
  } lcd_state_e;

  // Per-byte micro-sequence shared by every top-level state.
  typedef enum logic [2:0] {
    PhAddr, PhFetch, PhHiStart, PhHiWait, PhLoStart, PhLoWait, PhWait
  } lcd_phase_e;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET;
      2'd1:    b = ENTRY;
      2'd2:    b = DISP_ON;
      default: b = CLEAR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Emits one nibble on the LCD bus: setup, enable pulse, then a data-hold gap.
module lcd_nibble_writer #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_EH  = 12,
  parameter int unsigned T_NIB = 50
) (
  input  logic       cclk,
  input  logic       rstn,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       lcde,
  output logic       lcdrs,
  output logic [3:0] lcddat,
  output logic       done
);

  typedef enum logic [1:0] {WrIdle, WrSetup, WrHigh, WrHold} wr_state_e;

  wr_state_e  st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] dat_q, dat_d;
  logic       rs_q, rs_d;
  logic       e_q, e_d;

  always_ff @(posedge cclk) begin
    if (!rstn) begin
      st_q  <= WrIdle;
      cnt_q <= '0;
      dat_q <= '0;
      rs_q  <= 1'b0;
      e_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      rs_q  <= rs_d;
      e_q   <= e_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    rs_d  = rs_q;
    e_d   = e_q;
    done  = 1'b0;
    unique case (st_q)
      WrIdle: begin
        if (start) begin
          dat_d = nibble;
          rs_d  = rs;
          cnt_d = 8'(T_SU - 1);
          st_d  = WrSetup;
        end
      end
      WrSetup: begin
        if (cnt_q == '0) begin
          e_d   = 1'b1;
          cnt_d = 8'(T_EH - 1);
          st_d  = WrHigh;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WrHigh: begin
        if (cnt_q == '0) begin
          e_d   = 1'b0;
          cnt_d = 8'(T_NIB - 1);
          st_d  = WrHold;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WrHold: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          st_d = WrIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: st_d = WrIdle;
    endcase
  end

  assign lcde   = e_q;
  assign lcdrs  = rs_q;
  assign lcddat = dat_q;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// HD44780 4-bit bus driver: power-on init, then 2x16 frame copies on request.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_EH    = 12,
  parameter int unsigned T_NIB   = 50
) (
  input  logic              cclk,
  input  logic              rstn,
  input  logic              refresh,
  output logic [ADDR_W-1:0] char_addr,
  input  logic [7:0]        char_data,
  output logic              ready,
  output logic              busy,
  output logic              lcde,
  output logic              lcdrs,
  output logic              lcdrw,
  output logic [3:0]        lcddat
);

  lcd_state_e        st_q, st_d;
  lcd_phase_e        ph_q, ph_d;
  logic [19:0]       wcnt_q, wcnt_d, wait_len;
  logic [7:0]        byte_q, byte_d;
  logic              rs_q, rs_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              pend_q, pend_d;
  logic              wr_start, wr_done;
  logic [3:0]        wr_nib;

  always_ff @(posedge cclk) begin
    if (!rstn) begin
      st_q    <= StPwrup;
      ph_q    <= PhWait;
      wcnt_q  <= 20'(T_PWRUP - 1);
      byte_q  <= '0;
      rs_q    <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      wcnt_q  <= wcnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    case (st_q)
      StInitA: wait_len = 20'(T_INIT1 - 1);
      StInitB: wait_len = 20'(T_INIT2 - 1);
      default: wait_len = (byte_q == CLEAR && !rs_q) ? 20'(T_CLEAR - 1) : 20'(T_CMD - 1);
    endcase
  end

  always_comb begin
    st_d     = st_q;
    ph_d     = ph_q;
    wcnt_d   = wcnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    ready_d  = ready_q;
    pend_d   = pend_q | (refresh && st_q != StIdle);
    wr_start = 1'b0;
    wr_nib   = byte_q[3:0];
    if (st_q == StIdle) begin
      // A refresh on the start cycle is absorbed by this frame.
      if (refresh || pend_q) begin
        st_d   = StAddr1;
        ph_d   = PhHiStart;
        byte_d = LINE1;
        rs_d   = 1'b0;
        pend_d = 1'b0;
      end
    end else begin
      case (ph_q)
        PhAddr:  ph_d = PhFetch;
        PhFetch: begin
          byte_d = char_data;
          ph_d   = PhHiStart;
        end
        PhHiStart: begin
          wr_start = 1'b1;
          wr_nib   = byte_q[7:4];
          ph_d     = PhHiWait;
        end
        PhHiWait: if (wr_done) ph_d = PhLoStart;
        PhLoStart: begin
          wr_start = 1'b1;
          ph_d     = PhLoWait;
        end
        PhLoWait: begin
          if (wr_done) begin
            wcnt_d = wait_len;
            ph_d   = PhWait;
          end
        end
        PhWait: begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 20'd1;
          end else begin
            case (st_q)
              StPwrup, StInitA, StInitB: begin
                st_d   = (st_q == StPwrup) ? StInitA : (st_q == StInitA) ? StInitB : StInitC;
                byte_d = {4'h0, INIT_NIB};
                ph_d   = PhLoStart;
              end
              StInitC: begin
                st_d   = StInit4b;
                byte_d = {4'h0, FOURBIT_NIB};
                ph_d   = PhLoStart;
              end
              StInit4b: begin
                st_d   = StCfg;
                idx_d  = 2'd0;
                byte_d = cfg_byte(2'd0);
                ph_d   = PhHiStart;
              end
              StCfg: begin
                if (idx_q == 2'd3) begin
                  ready_d = 1'b1;
                  st_d    = StIdle;
                end else begin
                  idx_d  = idx_q + 2'd1;
                  byte_d = cfg_byte(idx_q + 2'd1);
                  ph_d   = PhHiStart;
                end
              end
              StAddr1, StAddr2: begin
                st_d = (st_q == StAddr1) ? StLine1 : StLine2;
                rs_d = 1'b1;
                ph_d = PhAddr;
              end
              StLine1: begin
                addr_d = addr_q + 5'd1;
                if (addr_q == 5'd15) begin
                  st_d   = StAddr2;
                  rs_d   = 1'b0;
                  byte_d = LINE2;
                  ph_d   = PhHiStart;
                end else begin
                  ph_d = PhAddr;
                end
              end
              StLine2: begin
                addr_d = addr_q + 5'd1;
                if (addr_q == 5'd31) st_d = StIdle;
                else ph_d = PhAddr;
              end
              default: st_d = StIdle;
            endcase
          end
        end
        default: ph_d = PhWait;
      endcase
    end
  end

  lcd_nibble_writer #(
    .T_SU  (T_SU),
    .T_EH  (T_EH),
    .T_NIB (T_NIB)
  ) u_writer (
    .cclk   (cclk),
    .rstn   (rstn),
    .start  (wr_start),
    .nibble (wr_nib),
    .rs     (rs_q),
    .lcde   (lcde),
    .lcdrs  (lcdrs),
    .lcddat (lcddat),
    .done   (wr_done)
  );

  assign char_addr = addr_q;
  assign ready     = ready_q;
  assign busy      = (st_q != StIdle);
  assign lcdrw     = 1'b0;

endmodule
